// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding, SPI mode constants and clog2 helper
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOW   = 3'd2,
    ST_HIGH  = 3'd3,
    ST_HOLD  = 3'd4
  } spi_state_e;

  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;

  // Never returns less than 1 so single-value counters still get a bit.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem = rem >> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/spi_master_ctrl_if.sv
// rtl/spi_master_ctrl_if.sv - host handshake and SPI pin bundle for the master
interface spi_master_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rx_data;
  logic              cs_n;
  logic              sclk;
  logic              mosi;
  logic              miso;

  modport master (
    input  start, tx_data, miso,
    output busy, done, rx_data, cs_n, sclk, mosi
  );

  modport slave (
    output start, tx_data, miso,
    input  busy, done, rx_data, cs_n, sclk, mosi
  );
endinterface

// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - half-period counter producing phase_end and the sclk level
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic launch,
  output logic phase_end,
  output logic sclk
);
  localparam int HP_W = clog2(CLK_DIV);

  logic [HP_W-1:0] hp_cnt;

  assign phase_end = en && (hp_cnt == HP_W'(CLK_DIV - 1));

  // launch opens the first high phase directly; the first low phase is the setup time.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hp_cnt <= '0;
      sclk   <= CPOL;
    end else if (launch) begin
      hp_cnt <= '0;
      sclk   <= ~CPOL;
    end else if (phase_end) begin
      hp_cnt <= '0;
      sclk   <= ~sclk;
    end else if (en) begin
      hp_cnt <= hp_cnt + 1'b1;
    end else begin
      hp_cnt <= '0;
      sclk   <= CPOL;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - SPI mode-0 master: start/busy/done host side, MSB-first shifting
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input logic               clk,
  input logic               reset_n,
  spi_master_ctrl_if.master bus
);
  localparam int BIT_W     = clog2(DATA_W + 1);
  localparam int GUARD_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int GUARD_W   = clog2(GUARD_MAX + 1);

  spi_state_e         state_q, state_d;
  logic [DATA_W-1:0]  tx_sr_q, tx_sr_d, tx_next;
  logic [DATA_W-1:0]  rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0]  rx_data_q, rx_data_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GUARD_W-1:0] guard_q, guard_d;
  logic               cs_n_q, cs_n_d, mosi_q, mosi_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               miso_meta, miso_s;
  logic               sclk_en, launch, phase_end, sclk_q;

  assign sclk_en = (state_q == ST_HIGH) || (state_q == ST_LOW);
  assign tx_next = tx_sr_q << 1;

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (sclk_en),
    .launch    (launch),
    .phase_end (phase_end),
    .sclk      (sclk_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    bit_cnt_d = bit_cnt_q;
    guard_d   = guard_q;
    cs_n_d    = cs_n_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    launch    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = '0;
        guard_d   = '0;
        if (bus.start) begin
          tx_sr_d = bus.tx_data;
          rx_sr_d = '0;
          mosi_d  = bus.tx_data[DATA_W-1];
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (guard_q == GUARD_W'(CS_SETUP - 1)) begin
          guard_d = '0;
          launch  = 1'b1;
          state_d = ST_HIGH;
        end else begin
          guard_d = guard_q + 1'b1;
        end
      end
      ST_HIGH: begin
        if (phase_end) begin
          rx_sr_d   = (rx_sr_q << 1) | DATA_W'(miso_s);
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
            state_d = ST_HOLD;
          end else begin
            // Next bit goes out on the same edge that drops sclk.
            tx_sr_d = tx_next;
            mosi_d  = tx_next[DATA_W-1];
            state_d = ST_LOW;
          end
        end
      end
      ST_LOW: begin
        if (phase_end) state_d = ST_HIGH;
      end
      ST_HOLD: begin
        if (guard_q == GUARD_W'(CS_HOLD - 1)) begin
          guard_d   = '0;
          cs_n_d    = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          rx_data_d = rx_sr_q;
          mosi_d    = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          guard_d = guard_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      bit_cnt_q <= '0;
      guard_q   <= '0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      miso_meta <= 1'b0;
      miso_s    <= 1'b0;
    end else begin
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      bit_cnt_q <= bit_cnt_d;
      guard_q   <= guard_d;
      cs_n_q    <= cs_n_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      miso_meta <= bus.miso;
      miso_s    <= miso_meta;
    end
  end

  assign bus.cs_n    = cs_n_q;
  assign bus.sclk    = sclk_q;
  assign bus.mosi    = mosi_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - directed bench for spi_master_ctrl (8-bit default and 16-bit/div-3 builds)
module tb_spi_master_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  spi_master_ctrl_if #(.DATA_W(8))  b1 ();
  spi_master_ctrl_if #(.DATA_W(16)) b2 ();

  spi_master_ctrl #(.DATA_W(8), .CLK_DIV(4), .CS_SETUP(2), .CS_HOLD(2)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(b1)
  );
  spi_master_ctrl #(.DATA_W(16), .CLK_DIV(3), .CS_SETUP(2), .CS_HOLD(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(b2)
  );

  int tests = 0;
  int fails = 0;

  // Mode-0 slave: MSB presented at select, next bit after each falling sclk edge.
  logic [7:0] slave_word = 8'h00;
  int s_cnt = 0;
  always @(negedge b1.sclk or posedge b1.cs_n) begin
    if (b1.cs_n) s_cnt = 0;
    else         s_cnt = s_cnt + 1;
  end
  assign b1.miso = (s_cnt < 8) ? slave_word[7 - s_cnt] : 1'b0;
  assign b2.miso = b2.mosi;

  int lat, rises, busy_hi, cs_fall_n, first_rise_n, last_fall_n, cs_rise_n;
  int hi_min, hi_max, lo_min, lo_max;
  logic [31:0] mosi_word;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic xfer1(input logic [7:0] tx, input logic [7:0] sw, input int inject_n);
    int run_hi, run_lo;
    logic prev_sclk;
    bit seen_fall, cs_seen;
    slave_word = sw;
    lat = 0; rises = 0; busy_hi = 0; cs_fall_n = 0; first_rise_n = 0;
    last_fall_n = 0; cs_rise_n = 0; mosi_word = '0;
    hi_min = 999; hi_max = 0; lo_min = 999; lo_max = 0;
    run_hi = 0; run_lo = 0; prev_sclk = 1'b0; seen_fall = 1'b0; cs_seen = 1'b0;
    @(negedge clk);
    b1.start = 1'b1;
    b1.tx_data = tx;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 1) begin b1.start = 1'b0; b1.tx_data = 8'h00; end
      if (n == inject_n) begin b1.start = 1'b1; b1.tx_data = 8'h11; end
      if (n == inject_n + 1) b1.start = 1'b0;
      if (!cs_seen && !b1.cs_n) begin cs_seen = 1'b1; cs_fall_n = n; end
      if (b1.busy) busy_hi++;
      if (b1.sclk && !prev_sclk) begin
        rises++;
        mosi_word = {mosi_word[30:0], b1.mosi};
        if (rises == 1) first_rise_n = n;
        if (seen_fall) begin
          if (run_lo < lo_min) lo_min = run_lo;
          if (run_lo > lo_max) lo_max = run_lo;
        end
        run_hi = 0;
      end
      if (!b1.sclk && prev_sclk) begin
        if (run_hi < hi_min) hi_min = run_hi;
        if (run_hi > hi_max) hi_max = run_hi;
        last_fall_n = n;
        seen_fall = 1'b1;
        run_lo = 0;
      end
      if (b1.sclk) run_hi++;
      else         run_lo++;
      if (cs_seen && b1.cs_n && cs_rise_n == 0) cs_rise_n = n;
      prev_sclk = b1.sclk;
      if (b1.done) begin lat = n; break; end
    end
    @(negedge clk);
    check("done_single_pulse", {31'd0, b1.done}, 32'd0);
    check("rx_held_after_done", {24'd0, b1.rx_data}, {24'd0, sw});
  endtask

  int nd, nb, nc, act;
  logic [7:0] m1, m2;
  logic prv;

  initial begin
    b1.start = 1'b0; b1.tx_data = '0;
    b2.start = 1'b0; b2.tx_data = '0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_cs_n",  {31'd0, b1.cs_n}, 32'd1);
    check("rst_sclk",  {31'd0, b1.sclk}, 32'd0);
    check("rst_mosi",  {31'd0, b1.mosi}, 32'd0);
    check("rst_busy",  {31'd0, b1.busy}, 32'd0);
    check("rst_done",  {31'd0, b1.done}, 32'd0);
    check("rst_rx",    {24'd0, b1.rx_data}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    xfer1(8'hA5, 8'h3C, 0);
    check("basic_latency",   lat, 65);
    check("basic_mosi_bits", mosi_word, 32'h0000_00A5);
    check("basic_rx",        {24'd0, b1.rx_data}, 32'h3C);
    check("basic_rises",     rises, 8);
    check("cs_fall_cycle",   cs_fall_n, 1);
    check("cs_to_first_rise", first_rise_n - cs_fall_n, 2);
    check("last_fall_to_cs", cs_rise_n - last_fall_n, 2);
    check("sclk_hi_min", hi_min, 4);
    check("sclk_hi_max", hi_max, 4);
    check("sclk_lo_min", lo_min, 4);
    check("sclk_lo_max", lo_max, 4);
    check("busy_cycles", busy_hi, 64);

    xfer1(8'hA5, 8'hC6, 20);
    check("ign_latency",   lat, 65);
    check("ign_mosi_bits", mosi_word, 32'h0000_00A5);
    check("ign_rx",        {24'd0, b1.rx_data}, 32'hC6);
    act = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (b1.busy || !b1.cs_n) act++;
    end
    check("ign_no_extra_xfer", act, 0);

    // Back-to-back with start held high; tx_data flips after the first accept.
    slave_word = 8'h69;
    nd = 0; nb = 0; nc = 0; m1 = '0; m2 = '0; rises = 0; prv = 1'b0; lat = 0;
    @(negedge clk);
    b1.start = 1'b1;
    b1.tx_data = 8'hFF;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (n == 1) b1.tx_data = 8'h00;
      if (b1.sclk && !prv) begin
        rises++;
        if (nd == 0) m1 = {m1[6:0], b1.mosi};
        else         m2 = {m2[6:0], b1.mosi};
      end
      prv = b1.sclk;
      if (!b1.busy) nb++;
      if (b1.cs_n)  nc++;
      if (b1.done) begin
        nd++;
        if (nd == 2) begin b1.start = 1'b0; lat = n; break; end
      end
    end
    check("b2b_done_count", nd, 2);
    check("b2b_total_cycles", lat, 130);
    check("b2b_busy_low_cycles", nb, 2);
    check("b2b_cs_high_cycles", nc, 2);
    check("b2b_first_mosi", {24'd0, m1}, 32'hFF);
    check("b2b_second_mosi", {24'd0, m2}, 32'h00);
    check("b2b_rises", rises, 16);
    check("b2b_rx", {24'd0, b1.rx_data}, 32'h69);
    repeat (3) @(negedge clk);
    check("b2b_idle_after", {30'd0, b1.busy, b1.cs_n}, 32'd1);

    // Reset while the 4th bit is high.
    slave_word = 8'h00;
    @(negedge clk);
    b1.start = 1'b1;
    b1.tx_data = 8'hFF;
    @(negedge clk);
    b1.start = 1'b0;
    repeat (27) @(negedge clk);
    check("pre_rst_active", {29'd0, b1.cs_n, b1.sclk, b1.mosi}, 32'b011);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_cs_n", {31'd0, b1.cs_n}, 32'd1);
    check("async_rst_sclk", {31'd0, b1.sclk}, 32'd0);
    check("async_rst_mosi", {31'd0, b1.mosi}, 32'd0);
    check("async_rst_busy", {31'd0, b1.busy}, 32'd0);
    check("async_rst_rx",   {24'd0, b1.rx_data}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    xfer1(8'h5A, 8'h96, 0);
    check("post_rst_latency", lat, 65);
    check("post_rst_mosi", mosi_word, 32'h0000_005A);
    check("post_rst_rx", {24'd0, b1.rx_data}, 32'h96);
    check("post_rst_rises", rises, 8);

    // 16-bit, CLK_DIV=3 build with miso looped back to mosi.
    rises = 0; prv = 1'b0; lat = 0;
    @(negedge clk);
    b2.start = 1'b1;
    b2.tx_data = 16'hC3A1;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (n == 1) begin b2.start = 1'b0; b2.tx_data = 16'h0000; end
      if (b2.sclk && !prv) rises++;
      prv = b2.sclk;
      if (b2.done) begin lat = n; break; end
    end
    check("w16_latency", lat, 98);
    check("w16_rx", {16'd0, b2.rx_data}, 32'hC3A1);
    check("w16_rises", rises, 16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
